// File: rtl/rcount_pkg.sv
// Shared types and widths for the ripple-counter sampler.
package rcount_pkg;
    localparam int COUNT_W = 4;
    localparam int WRAP_W  = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        DONE
    } state_e;
endpackage

// File: rtl/rcount_sync.sv
// Two-flop synchronizer for the ripple count plus a saturating stability filter.
module rcount_sync
    import rcount_pkg::*;
#(
    parameter int STABLE_CYCLES = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [COUNT_W-1:0] count_in,
    output logic [COUNT_W-1:0] raw,
    output logic               stable
);
    localparam logic [3:0] STAB_MAX = 4'(STABLE_CYCLES);

    logic [COUNT_W-1:0] s1_q, s1_d, raw_q, raw_d;
    logic [3:0]         stab_cnt_q, stab_cnt_d;

    // s1_q is next cycle's raw, so comparing it with raw_q lets stab_cnt_q
    // describe the raw value currently visible rather than lagging by a cycle.
    always_comb begin
        s1_d  = count_in;
        raw_d = s1_q;
        if (s1_q == raw_q)
            stab_cnt_d = (stab_cnt_q == STAB_MAX) ? stab_cnt_q : stab_cnt_q + 4'd1;
        else
            stab_cnt_d = 4'd0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_q       <= '0;
            raw_q      <= '0;
            stab_cnt_q <= 4'd0;
        end else begin
            s1_q       <= s1_d;
            raw_q      <= raw_d;
            stab_cnt_q <= stab_cnt_d;
        end
    end

    assign raw    = raw_q;
    assign stable = (stab_cnt_q == STAB_MAX);
endmodule

// File: rtl/rcount_sampler.sv
// Capture FSM for an asynchronous ripple counter, with optional wrap tracking
// compiled in by RCOUNT_WRAP_TRACK_EN.
module rcount_sampler
    import rcount_pkg::*;
#(
    parameter int STABLE_CYCLES = 2,
    parameter int TIMEOUT       = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [COUNT_W-1:0] count_in,
    input  logic               sample_req,
    output logic               busy,
    output logic [COUNT_W-1:0] count_out,
    output logic               valid,
    output logic               err,
    output logic               wrap_pulse,
    output logic [WRAP_W-1:0]  wrap_count
);
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    logic [COUNT_W-1:0] raw;
    logic               stable;

    rcount_sync #(.STABLE_CYCLES(STABLE_CYCLES)) u_sync (
        .clock    (clock),
        .reset    (reset),
        .count_in (count_in),
        .raw      (raw),
        .stable   (stable)
    );

    state_e             state_q, state_d;
    logic [7:0]         timer_q, timer_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               busy_q, busy_d, valid_q, valid_d, err_q, err_d;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        count_d = count_q;
        valid_d = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            IDLE: if (sample_req) begin
                state_d = SETTLE;
                timer_d = 8'd0;
            end
            // A stable sample wins even on the final timeout cycle.
            SETTLE: if (stable) begin
                count_d = raw;
                valid_d = 1'b1;
                state_d = DONE;
            end else if (timer_q == TIMER_LAST) begin
                err_d   = 1'b1;
                state_d = IDLE;
            end else begin
                timer_d = timer_q + 8'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            timer_q <= 8'd0;
            count_q <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            count_q <= count_d;
            busy_q  <= busy_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign busy      = busy_q;
    assign count_out = count_q;
    assign valid     = valid_q;
    assign err       = err_q;

`ifdef RCOUNT_WRAP_TRACK_EN
    logic [COUNT_W-1:0] last_stable_q, last_stable_d;
    logic               wrap_pulse_q, wrap_pulse_d;
    logic [WRAP_W-1:0]  wrap_count_q, wrap_count_d;

    always_comb begin
        last_stable_d = last_stable_q;
        wrap_pulse_d  = 1'b0;
        wrap_count_d  = wrap_count_q;
        if (stable) begin
            if (raw < last_stable_q) begin
                wrap_pulse_d = 1'b1;
                wrap_count_d = wrap_count_q + 8'd1;
            end
            last_stable_d = raw;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_stable_q <= '0;
            wrap_pulse_q  <= 1'b0;
            wrap_count_q  <= '0;
        end else begin
            last_stable_q <= last_stable_d;
            wrap_pulse_q  <= wrap_pulse_d;
            wrap_count_q  <= wrap_count_d;
        end
    end

    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_count_q;
`else
    assign wrap_pulse = 1'b0;
    assign wrap_count = '0;
`endif
endmodule

// File: doc/rcount_sampler.md
RCOUNT_SAMPLER -- requirements
Module: rcount_sampler

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 2: consecutive equal synchronized samples required to declare the value stable; legal range 1..15.
REQ-002 SHALL have parameter TIMEOUT, default 16: maximum SETTLE cycles before the capture aborts; legal range 2..255.
REQ-003 SHALL have port clock, input, 1: single rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port count_in, input, 4: ripple-counter q[3:0], asynchronous to clock.
REQ-006 SHALL have port sample_req, input, 1: capture request, sampled only in IDLE.
REQ-007 SHALL have port busy, output, 1: high while the FSM is in SETTLE or DONE.
REQ-008 SHALL have port count_out, output, 4: last successfully captured count.
REQ-009 SHALL have port valid, output, 1: one-cycle pulse when count_out updates.
REQ-010 SHALL have port err, output, 1: one-cycle pulse on capture timeout.
REQ-011 SHALL have port wrap_pulse, output, 1: one-cycle pulse on detected counter wrap.
REQ-012 SHALL have port wrap_count, output, 8: number of wraps, modulo 256.

Function
REQ-013 SHALL pass count_in through a two-flop synchronizer; raw = second-stage value.
REQ-014 SHALL compare raw against the previous cycle's raw: equal -> stab_cnt increments, saturating at STABLE_CYCLES; unequal -> stab_cnt = 0.
REQ-015 SHALL define stable = (stab_cnt == STABLE_CYCLES).
REQ-016 SHALL implement FSM states IDLE, SETTLE and DONE.
REQ-017 In IDLE, sample_req=1 SHALL move to SETTLE and clear timer.
REQ-018 In SETTLE, stable=1 SHALL load count_out <= raw and move to DONE.
REQ-019 In SETTLE with stable=0, timer SHALL increment; on timer == TIMEOUT-1 the FSM SHALL pulse err, return to IDLE and leave count_out unchanged.
REQ-020 If stable and timeout coincide, capture SHALL take priority: count_out is loaded and err stays 0.
REQ-021 In DONE, valid SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
REQ-022 sample_req SHALL be ignored outside IDLE; requests are not queued.
REQ-023 Latency: with count_in already stable, valid SHALL assert in the 2nd cycle after the edge that samples sample_req.
REQ-024 Wrap tracker (see Configuration) SHALL run independently of the FSM: on every stable cycle, if raw < last_stable, pulse wrap_pulse and increment wrap_count (255 -> 0 wraps); then last_stable <= raw.

Reset
REQ-025 Assertion of reset SHALL immediately force: FSM = IDLE; synchronizer flops, stab_cnt, timer, last_stable = 0; count_out = 4'h0; busy, valid, err, wrap_pulse = 0; wrap_count = 8'h00.
REQ-026 Reset mid-capture SHALL abandon the capture without a valid or err pulse.
REQ-027 Release of reset SHALL take effect at the next rising clock edge.

Configuration
REQ-028 With macro RCOUNT_WRAP_TRACK_EN defined, the wrap tracker in REQ-024 SHALL be compiled in.
REQ-029 Without RCOUNT_WRAP_TRACK_EN, last_stable SHALL be absent, and wrap_pulse and wrap_count SHALL be constant 0; all other behaviour is unchanged.

Structure
REQ-030 Package rcount_pkg SHALL hold the FSM state typedef (IDLE, SETTLE, DONE), COUNT_W=4 and WRAP_W=8.
REQ-031 Sub-module rcount_sync SHALL contain the two-flop synchronizer and the stability filter, and output raw and stable; rcount_sampler holds the FSM, timer and wrap tracker.

Verification
REQ-032 SHALL cover: count_in held 4'h5, one sample_req pulse -> valid pulse exactly 2 cycles later, count_out=4'h5, err=0.
REQ-033 SHALL cover: count_in toggling every cycle, sample_req -> err pulse after 16 SETTLE cycles, count_out unchanged, valid=0.
REQ-034 SHALL cover: count_in steps 4'hE -> 4'hF -> 4'h0, each held 5 cycles (macro defined) -> one wrap_pulse, wrap_count 0 -> 1; macro undefined -> wrap_pulse and wrap_count stay 0.
REQ-035 SHALL cover: reset asserted during SETTLE -> all outputs 0 immediately; no valid or err after release.
REQ-036 SHALL cover: sample_req held high for 10 cycles with count_in stable -> one valid per IDLE->SETTLE->DONE loop, i.e. a valid pulse every 3 cycles.
REQ-037 SHALL cover: 256 wraps (macro defined) -> wrap_count returns to 8'h00.
